// File: rtl/motor_input_cond_pkg.sv
// Shared definitions for the motor input conditioning stage: button FSM
// encoding, default debounce length and the debounce counter width rule.
package motor_input_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic {
    BTN_IDLE = 1'b0,
    BTN_HELD = 1'b1
  } btn_state_e;

  // Counter must reach DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/motor_input_cond_if.sv
// Raw switch inputs and conditioned outputs exchanged between the board-side
// environment and the input conditioning stage.
interface motor_input_cond_if;

  logic btn_raw;
  logic up_limit_raw;
  logic dn_limit_raw;
  logic fault_clr;
  logic activate;
  logic up_limit;
  logic dn_limit;
  logic limit_fault;

  // Environment side: drives raw switches and fault clear.
  modport master (
    output btn_raw, up_limit_raw, dn_limit_raw, fault_clr,
    input  activate, up_limit, dn_limit, limit_fault
  );

  // Conditioning stage side.
  modport slave (
    input  btn_raw, up_limit_raw, dn_limit_raw, fault_clr,
    output activate, up_limit, dn_limit, limit_fault
  );

endinterface

// File: rtl/motor_debounce.sv
// Single-bit two-flop synchronizer followed by a counting debouncer; the
// stable value flips only after DEBOUNCE_CYCLES consecutive differing samples.
module motor_debounce
  import motor_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s = sync_q[1];

  // NOTE: every output of an always_comb is defaulted first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s != db_q) begin
      if (cnt_q == CNT_TERM) begin
        db_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the synchronizer flops are reset too, so nothing reaches the
  // debouncer before the first real sample after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q <= {sync_q[0], din};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/motor_input_cond.sv
// Conditions the push-button and both limit switches, generates one activate
// pulse per press and latches a fault when both limits read closed together.
module motor_input_cond
  import motor_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  motor_input_cond_if.slave   bus
);

  logic       btn_db;
  logic       up_db;
  logic       dn_db;
  btn_state_e state_q, state_d;
  logic       activate_q, activate_d;
  logic       limit_fault_q, limit_fault_d;

  motor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.btn_raw),
    .dout (btn_db)
  );

  motor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.up_limit_raw),
    .dout (up_db)
  );

  motor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.dn_limit_raw),
    .dout (dn_db)
  );

  // Set dominates clear: a clear only takes effect once the condition is gone.
  always_comb begin
    limit_fault_d = limit_fault_q;
    if (up_db && dn_db) begin
      limit_fault_d = 1'b1;
    end else if (bus.fault_clr) begin
      limit_fault_d = 1'b0;
    end
  end

  // A press is consumed on entry to BTN_HELD, even when the fault masks the
  // pulse, so clearing the fault mid-press never produces a late pulse.
  always_comb begin
    state_d    = state_q;
    activate_d = 1'b0;
    unique case (state_q)
      BTN_IDLE: begin
        if (btn_db) begin
          state_d    = BTN_HELD;
          activate_d = ~limit_fault_q;
        end
      end
      BTN_HELD: begin
        if (!btn_db) begin
          state_d = BTN_IDLE;
        end
      end
      default: state_d = BTN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BTN_IDLE;
      activate_q    <= 1'b0;
      limit_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      activate_q    <= activate_d;
      limit_fault_q <= limit_fault_d;
    end
  end

  assign bus.activate    = activate_q;
  assign bus.up_limit    = up_db;
  assign bus.dn_limit    = dn_db;
  assign bus.limit_fault = limit_fault_q;

endmodule
